nn_cfg_sequencer: RTL and testbench
===================================

Name: nn_cfg_sequencer

Overview:
- Streams per-layer weights and biases into the layer array: one 32-bit word stream in, one per-beat config strobe out.
- Drives the layer/neuron select, the value buses and the valid strobes consumed by every Layer_N instance.
- Sits between the config DMA/AXI-Stream source and the layer array. Replaces per-word software register writes.
- Load order: layer 1..NUM_LAYERS; within a layer, neuron 0..NN-1; per neuron, numWeight weights followed by 1 bias.

Parameters:
- DATA_W, 32: width of stream words and value outputs.
- NUM_LAYERS, 5: number of layers to load (1..8).
- NEURON_CNTS, packed NUM_LAYERS×16: neuron count per layer; layer 1 in bits [15:0].
- WEIGHT_CNTS, packed NUM_LAYERS×16: weights per neuron for each layer; layer 1 in bits [15:0].

Ports:
- s_axi_aclk, in, 1: clock.
- s_axi_aresetn, in, 1: asynchronous active-low reset.
- start, in, 1: single-cycle pulse that begins a load.
- abort, in, 1: synchronous abort (softReset).
- cfg_in_data, in, DATA_W: stream word.
- cfg_in_valid, in, 1: stream valid.
- cfg_in_ready, out, 1: stream ready.
- layerNumber, out, 32: 1-based layer being loaded.
- neuronNumber, out, 32: 0-based neuron being loaded.
- weightValue, out, DATA_W: weight word.
- weightValid, out, 1: one-cycle strobe per weight.
- biasValue, out, DATA_W: bias word.
- biasValid, out, 1: one-cycle strobe per bias.
- busy, out, 1: a load is in progress.
- done, out, 1: one-cycle pulse when the load completes.
- loaded, out, 1: level, set on done.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; all counters 0.
  - layerNumber=1, neuronNumber=0.
  - weightValue, biasValue = 0.
  - weightValid, biasValid, busy, done, loaded, cfg_in_ready = 0.
- States:
  - IDLE -> WEIGHT on start. Clears loaded and all counters; busy=1.
  - WEIGHT: each accepted beat (valid & ready) increments wcnt. At wcnt==WEIGHT_CNTS[L]-1, go to BIAS.
  - BIAS: one accepted beat. If the neuron is not the last, ncnt++ and go to WEIGHT. If it is the last neuron and not the last layer, layer++, ncnt=0, go to WEIGHT. If it is the last of both, go to DONE.
  - DONE: exactly one cycle. done=1, loaded<=1, busy<=0, then IDLE.
- cfg_in_ready = 1 in WEIGHT/BIAS only, driven combinationally from state (no dependency on valid).
- Output timing:
  - Accepted beat in cycle t drives value and strobe in cycle t+1 (latency 1).
  - layerNumber/neuronNumber in cycle t+1 carry the index of that beat, not the next index.
  - weightValue/biasValue hold their last value when no strobe is active.
- Stall: cfg_in_valid low freezes all counters; strobes are low in stalled cycles.
- A layer with WEIGHT_CNTS=0 goes straight to BIAS for each neuron. A layer with NEURON_CNTS=0 is skipped.
- start while busy: ignored.
- abort, any state: next cycle is IDLE with counters cleared, busy=0, loaded=0, strobes 0, no done. A beat accepted in the abort cycle is discarded. abort overrides a simultaneous start.
- Counter widths: 16-bit wcnt/ncnt, $clog2(NUM_LAYERS+1) layer counter. Comparisons use NUM_LAYERS-indexed slices of the packed parameters.

Optional Feature:
- Macro: NN_CFG_CHECKSUM_EN.
- When defined:
  - Extra output cfg_checksum, 32 bits: mod-2^32 running sum of every accepted word.
  - Cleared on start/abort/reset; updated on the same cycle as the strobe; valid when done pulses.
  - Extra input exp_checksum, 32 bits. On DONE, loaded is set only if the sums match.
  - Extra output cksum_err: level, set on mismatch, cleared by start/abort.
- When undefined: none of these ports exist; loaded is always set on DONE.

Decomposition:
- Package nn_cfg_pkg: state enum (IDLE, WEIGHT, BIAS, DONE), 16-bit count typedef, and a function extracting a 16-bit slice from the packed count parameters.
- One sub-module, nn_cfg_index_counter: nested weight/neuron/layer counters with last_weight/last_neuron/last_layer flags. The FSM and output registers stay in the top.

Test Plan (NUM_LAYERS=2, NEURON_CNTS={1,2}, WEIGHT_CNTS={2,3}; 11 beats total):
- Continuous-valid load of words 1..11:
  - weightValid on words 1-3, 5-7, 9-10; biasValid on 4, 8, 11.
  - Layer 1 (words 1-8): neuronNumber 0 on words 1-4, 1 on words 5-8.
  - Layer 2 (words 9-11): neuronNumber 0.
  - done exactly 1 cycle after the word-11 strobe; loaded=1.
- Random valid gaps (50%): identical strobe/value sequence to the first test; no strobe in gap cycles; counters held.
- abort asserted on beat 6: following cycle is IDLE, cfg_in_ready=0, busy=0, no done. A new start then reloads from layer 1 neuron 0.
- start pulsed mid-load at beat 3: ignored. Sequence completes with 11 beats; done fires once.
- Async reset mid-load (beat 5): all outputs 0, layerNumber=1 immediately. Stream beats after reset release are not accepted until start.
- NN_CFG_CHECKSUM_EN, words 1..11:
  - cfg_checksum=66 at done.
  - exp_checksum=66 gives loaded=1, cksum_err=0.
  - exp_checksum=67 gives loaded=0, cksum_err=1.

Source files
------------

// File: rtl/nn_cfg_pkg.sv
// rtl/nn_cfg_pkg.sv - shared types and count-slice helper for the layer config sequencer
package nn_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WEIGHT,
        BIAS,
        DONE
    } state_t;

    typedef logic [15:0] cnt_t;

    // Packed count parameters are widened to the largest supported array before slicing
    localparam int MAX_LAYERS = 8;
    localparam int PACK_W     = MAX_LAYERS * 16;

    function automatic cnt_t cnt_slice(input logic [PACK_W-1:0] vec, input int idx);
        return vec[idx*16 +: 16];
    endfunction

endpackage

// File: rtl/nn_cfg_index_counter.sv
// rtl/nn_cfg_index_counter.sv - nested weight/neuron/layer counters with end-of-range flags
module nn_cfg_index_counter
    import nn_cfg_pkg::*;
#(
    parameter int                       NUM_LAYERS  = 5,
    parameter logic [NUM_LAYERS*16-1:0] NEURON_CNTS = {NUM_LAYERS{16'd1}},
    parameter logic [NUM_LAYERS*16-1:0] WEIGHT_CNTS = {NUM_LAYERS{16'd1}},
    parameter int                       LW          = $clog2(NUM_LAYERS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          load,
    input  logic          inc_weight,
    input  logic          inc_neuron,
    input  logic          inc_layer,
    output cnt_t          ncnt,
    output logic [LW-1:0] lcnt,
    output logic          last_weight,
    output logic          last_neuron,
    output logic          last_layer,
    output logic          any_layer,
    output logic          first_wzero,
    output logic          cur_wzero,
    output logic          next_wzero
);

    localparam logic [PACK_W-1:0] N_EXT = PACK_W'(NEURON_CNTS);
    localparam logic [PACK_W-1:0] W_EXT = PACK_W'(WEIGHT_CNTS);

    cnt_t          wcnt;
    cnt_t          cur_n;
    cnt_t          cur_w;
    logic [LW-1:0] first_idx;
    logic [LW-1:0] next_idx;
    logic          next_found;

    // Locate the first non-empty layer and the next non-empty layer after the current one
    always_comb begin
        any_layer  = 1'b0;
        first_idx  = '0;
        next_found = 1'b0;
        next_idx   = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (cnt_slice(N_EXT, i) != '0) begin
                any_layer = 1'b1;
                first_idx = LW'(i);
                if (i > int'(lcnt)) begin
                    next_found = 1'b1;
                    next_idx   = LW'(i);
                end
            end
        end
    end

    assign cur_n       = cnt_slice(N_EXT, int'(lcnt));
    assign cur_w       = cnt_slice(W_EXT, int'(lcnt));
    assign last_weight = (wcnt == cur_w - 16'd1);
    assign last_neuron = (ncnt == cur_n - 16'd1);
    assign last_layer  = !next_found;
    assign cur_wzero   = (cur_w == '0);
    assign first_wzero = (cnt_slice(W_EXT, int'(first_idx)) == '0);
    assign next_wzero  = (cnt_slice(W_EXT, int'(next_idx)) == '0);

    // Advance the nested counters; the weight count wraps to zero on the last weight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= '0;
            ncnt <= '0;
            lcnt <= '0;
        end else if (clear) begin
            wcnt <= '0;
            ncnt <= '0;
            lcnt <= '0;
        end else if (load) begin
            wcnt <= '0;
            ncnt <= '0;
            lcnt <= first_idx;
        end else if (inc_layer) begin
            wcnt <= '0;
            ncnt <= '0;
            lcnt <= next_idx;
        end else if (inc_neuron) begin
            wcnt <= '0;
            ncnt <= ncnt + 16'd1;
        end else if (inc_weight) begin
            wcnt <= last_weight ? '0 : wcnt + 16'd1;
        end
    end

endmodule

// File: rtl/nn_cfg_sequencer.sv
// rtl/nn_cfg_sequencer.sv - streams layer weights/biases into the layer array (option: NN_CFG_CHECKSUM_EN)
module nn_cfg_sequencer
    import nn_cfg_pkg::*;
#(
    parameter int                       DATA_W      = 32,
    parameter int                       NUM_LAYERS  = 5,
    parameter logic [NUM_LAYERS*16-1:0] NEURON_CNTS = {NUM_LAYERS{16'd4}},
    parameter logic [NUM_LAYERS*16-1:0] WEIGHT_CNTS = {NUM_LAYERS{16'd8}}
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_aresetn,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] cfg_in_data,
    input  logic              cfg_in_valid,
    output logic              cfg_in_ready,
    output logic [31:0]       layerNumber,
    output logic [31:0]       neuronNumber,
    output logic [DATA_W-1:0] weightValue,
    output logic              weightValid,
    output logic [DATA_W-1:0] biasValue,
    output logic              biasValid,
    output logic              busy,
    output logic              done,
    output logic              loaded
`ifdef NN_CFG_CHECKSUM_EN
    ,
    input  logic [31:0]       exp_checksum,
    output logic [31:0]       cfg_checksum,
    output logic              cksum_err
`endif
);

    localparam int LW = $clog2(NUM_LAYERS + 1);

    state_t        state;
    cnt_t          ncnt;
    logic [LW-1:0] lcnt;
    logic          last_weight;
    logic          last_neuron;
    logic          last_layer;
    logic          any_layer;
    logic          first_wzero;
    logic          cur_wzero;
    logic          next_wzero;
    logic          beat;
    logic          do_load;
    logic          inc_weight;
    logic          inc_neuron;
    logic          inc_layer;

    assign cfg_in_ready = (state == WEIGHT) || (state == BIAS);
    assign beat         = cfg_in_valid && cfg_in_ready && !abort;
    assign do_load      = start && !abort && (state == IDLE);
    assign inc_weight   = beat && (state == WEIGHT);
    assign inc_neuron   = beat && (state == BIAS) && !last_neuron;
    assign inc_layer    = beat && (state == BIAS) && last_neuron && !last_layer;

    nn_cfg_index_counter #(
        .NUM_LAYERS  (NUM_LAYERS),
        .NEURON_CNTS (NEURON_CNTS),
        .WEIGHT_CNTS (WEIGHT_CNTS),
        .LW          (LW)
    ) u_index (
        .clk         (s_axi_aclk),
        .rst_n       (s_axi_aresetn),
        .clear       (abort),
        .load        (do_load),
        .inc_weight  (inc_weight),
        .inc_neuron  (inc_neuron),
        .inc_layer   (inc_layer),
        .ncnt        (ncnt),
        .lcnt        (lcnt),
        .last_weight (last_weight),
        .last_neuron (last_neuron),
        .last_layer  (last_layer),
        .any_layer   (any_layer),
        .first_wzero (first_wzero),
        .cur_wzero   (cur_wzero),
        .next_wzero  (next_wzero)
    );

    // Load FSM with registered strobes, values, indices and status
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state        <= IDLE;
            layerNumber  <= 32'd1;
            neuronNumber <= 32'd0;
            weightValue  <= '0;
            biasValue    <= '0;
            weightValid  <= 1'b0;
            biasValid    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            loaded       <= 1'b0;
`ifdef NN_CFG_CHECKSUM_EN
            cfg_checksum <= '0;
            cksum_err    <= 1'b0;
`endif
        end else begin
            weightValid <= 1'b0;
            biasValid   <= 1'b0;
            done        <= 1'b0;
            if (abort) begin
                state        <= IDLE;
                layerNumber  <= 32'd1;
                neuronNumber <= 32'd0;
                busy         <= 1'b0;
                loaded       <= 1'b0;
`ifdef NN_CFG_CHECKSUM_EN
                cfg_checksum <= '0;
                cksum_err    <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            busy   <= 1'b1;
                            loaded <= 1'b0;
`ifdef NN_CFG_CHECKSUM_EN
                            cfg_checksum <= '0;
                            cksum_err    <= 1'b0;
`endif
                            if (!any_layer)
                                state <= DONE;
                            else
                                state <= first_wzero ? BIAS : WEIGHT;
                        end
                    end
                    WEIGHT: begin
                        if (beat) begin
                            weightValue  <= cfg_in_data;
                            weightValid  <= 1'b1;
                            layerNumber  <= 32'(lcnt) + 32'd1;
                            neuronNumber <= 32'(ncnt);
`ifdef NN_CFG_CHECKSUM_EN
                            cfg_checksum <= cfg_checksum + 32'(cfg_in_data);
`endif
                            if (last_weight)
                                state <= BIAS;
                        end
                    end
                    BIAS: begin
                        if (beat) begin
                            biasValue    <= cfg_in_data;
                            biasValid    <= 1'b1;
                            layerNumber  <= 32'(lcnt) + 32'd1;
                            neuronNumber <= 32'(ncnt);
`ifdef NN_CFG_CHECKSUM_EN
                            cfg_checksum <= cfg_checksum + 32'(cfg_in_data);
`endif
                            if (!last_neuron)
                                state <= cur_wzero ? BIAS : WEIGHT;
                            else if (!last_layer)
                                state <= next_wzero ? BIAS : WEIGHT;
                            else
                                state <= DONE;
                        end
                    end
                    DONE: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
`ifdef NN_CFG_CHECKSUM_EN
                        loaded    <= (cfg_checksum == exp_checksum);
                        cksum_err <= (cfg_checksum != exp_checksum);
`else
                        loaded    <= 1'b1;
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nn_cfg_sequencer.sv
// tb/tb_nn_cfg_sequencer.sv - directed self-checking bench for nn_cfg_sequencer
module tb_nn_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] cfg_in_data;
    logic        cfg_in_valid;
    logic        cfg_in_ready;
    logic [31:0] layerNumber;
    logic [31:0] neuronNumber;
    logic [31:0] weightValue;
    logic        weightValid;
    logic [31:0] biasValue;
    logic        biasValid;
    logic        busy;
    logic        done;
    logic        loaded;
`ifdef NN_CFG_CHECKSUM_EN
    logic [31:0] exp_checksum;
    logic [31:0] cfg_checksum;
    logic        cksum_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nn_cfg_sequencer #(
        .DATA_W      (32),
        .NUM_LAYERS  (2),
        .NEURON_CNTS (32'h0001_0002),
        .WEIGHT_CNTS (32'h0002_0003)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .start         (start),
        .abort         (abort),
        .cfg_in_data   (cfg_in_data),
        .cfg_in_valid  (cfg_in_valid),
        .cfg_in_ready  (cfg_in_ready),
        .layerNumber   (layerNumber),
        .neuronNumber  (neuronNumber),
        .weightValue   (weightValue),
        .weightValid   (weightValid),
        .biasValue     (biasValue),
        .biasValid     (biasValid),
        .busy          (busy),
        .done          (done),
        .loaded        (loaded)
`ifdef NN_CFG_CHECKSUM_EN
        ,
        .exp_checksum  (exp_checksum),
        .cfg_checksum  (cfg_checksum),
        .cksum_err     (cksum_err)
`endif
    );

    task automatic test_reset();
        n_tests++; if (layerNumber !== 32'd1) begin n_fail++; $display("FAIL reset_layer got %0d exp 1", layerNumber); end
        n_tests++; if (neuronNumber !== 32'd0) begin n_fail++; $display("FAIL reset_neuron got %0d exp 0", neuronNumber); end
        n_tests++; if ({weightValid, biasValid, busy, done, loaded, cfg_in_ready} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags got %b exp 000000", {weightValid, biasValid, busy, done, loaded, cfg_in_ready}); end
        n_tests++; if ({weightValue, biasValue} !== 64'd0) begin n_fail++; $display("FAIL reset_values got %h exp 0", {weightValue, biasValue}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++; if ({busy, cfg_in_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_idle got %b exp 00", {busy, cfg_in_ready}); end
    endtask

    task automatic test_load(input bit gaps, input int start_at, input string tag);
        int  k;
        int  seen;
        int  last_w;
        bit  acc;
        bit  is_b;
        int  exp_l;
        int  exp_n;
        k = 1; seen = 0; last_w = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_tests++; if (busy !== 1'b1 || loaded !== 1'b0) begin n_fail++; $display("FAIL %s start_status got busy=%0b loaded=%0b exp 1 0", tag, busy, loaded); end
        for (int cyc = 0; cyc < 200 && seen < 11; cyc++) begin
            acc = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            cfg_in_valid = acc;
            cfg_in_data  = 32'(k);
            start        = (k == start_at) && acc;
            #1;
            n_tests++; if (cfg_in_ready !== 1'b1) begin n_fail++; $display("FAIL %s ready word %0d got %0b exp 1", tag, k, cfg_in_ready); end
            @(posedge clk); #1;
            start = 1'b0;
            cfg_in_valid = 1'b0;
            if (acc) begin
                seen++;
                is_b  = (k == 4 || k == 8 || k == 11);
                exp_l = (k <= 8) ? 1 : 2;
                exp_n = (k >= 5 && k <= 8) ? 1 : 0;
                n_tests++; if (weightValid !== !is_b || biasValid !== is_b) begin
                    n_fail++; $display("FAIL %s strobe word %0d got w=%0b b=%0b exp w=%0b b=%0b", tag, k, weightValid, biasValid, !is_b, is_b); end
                if (is_b) begin
                    n_tests++; if (biasValue !== 32'(k)) begin n_fail++; $display("FAIL %s bias_value got %0d exp %0d", tag, biasValue, k); end
                end else begin
                    n_tests++; if (weightValue !== 32'(k)) begin n_fail++; $display("FAIL %s weight_value got %0d exp %0d", tag, weightValue, k); end
                    last_w = k;
                end
                n_tests++; if (layerNumber !== 32'(exp_l) || neuronNumber !== 32'(exp_n)) begin
                    n_fail++; $display("FAIL %s index word %0d got L%0d N%0d exp L%0d N%0d", tag, k, layerNumber, neuronNumber, exp_l, exp_n); end
                k++;
            end else begin
                n_tests++; if (weightValid !== 1'b0 || biasValid !== 1'b0) begin
                    n_fail++; $display("FAIL %s gap_strobe got w=%0b b=%0b exp 0 0", tag, weightValid, biasValid); end
                if (last_w > 0) begin
                    n_tests++; if (weightValue !== 32'(last_w)) begin n_fail++; $display("FAIL %s gap_hold got %0d exp %0d", tag, weightValue, last_w); end
                end
            end
            n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s early_done got 1 exp 0", tag); end
        end
        n_tests++; if (seen != 11) begin n_fail++; $display("FAIL %s timeout beats got %0d exp 11", tag, seen); end
        @(posedge clk); #1;
        n_tests++; if (done !== 1'b1 || loaded !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL %s done got done=%0b loaded=%0b busy=%0b exp 1 1 0", tag, done, loaded, busy); end
        n_tests++; if (cfg_in_ready !== 1'b0) begin n_fail++; $display("FAIL %s ready_after_done got 1 exp 0", tag); end
`ifdef NN_CFG_CHECKSUM_EN
        n_tests++; if (cfg_checksum !== 32'd66 || cksum_err !== 1'b0) begin
            n_fail++; $display("FAIL %s checksum got %0d err=%0b exp 66 0", tag, cfg_checksum, cksum_err); end
`endif
        @(posedge clk); #1;
        n_tests++; if (done !== 1'b0 || loaded !== 1'b1) begin
            n_fail++; $display("FAIL %s done_once got done=%0b loaded=%0b exp 0 1", tag, done, loaded); end
    endtask

    task automatic test_abort();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int w = 1; w <= 5; w++) begin
            cfg_in_valid = 1'b1; cfg_in_data = 32'(w);
            @(posedge clk); #1;
        end
        cfg_in_valid = 1'b1; cfg_in_data = 32'd6; abort = 1'b1;
        @(posedge clk); #1;
        cfg_in_valid = 1'b0; abort = 1'b0;
        n_tests++; if (weightValid !== 1'b0 || biasValid !== 1'b0) begin
            n_fail++; $display("FAIL abort_discard got w=%0b b=%0b exp 0 0", weightValid, biasValid); end
        n_tests++; if ({cfg_in_ready, busy, done, loaded} !== 4'b0000) begin
            n_fail++; $display("FAIL abort_state got %b exp 0000", {cfg_in_ready, busy, done, loaded}); end
        @(posedge clk); #1;
        n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got done=%0b busy=%0b exp 0 0", done, busy); end
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int w = 1; w <= 4; w++) begin
            cfg_in_valid = 1'b1; cfg_in_data = 32'(w);
            @(posedge clk); #1;
        end
        cfg_in_valid = 1'b1; cfg_in_data = 32'd5;
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (layerNumber !== 32'd1 || neuronNumber !== 32'd0) begin
            n_fail++; $display("FAIL rstmid_index got L%0d N%0d exp L1 N0", layerNumber, neuronNumber); end
        n_tests++; if ({weightValid, biasValid, busy, done, loaded, cfg_in_ready} !== 6'b0) begin
            n_fail++; $display("FAIL rstmid_flags got %b exp 000000", {weightValid, biasValid, busy, done, loaded, cfg_in_ready}); end
        n_tests++; if ({weightValue, biasValue} !== 64'd0) begin n_fail++; $display("FAIL rstmid_values got %h exp 0", {weightValue, biasValue}); end
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_tests++; if ({cfg_in_ready, weightValid, biasValid, busy} !== 4'b0000) begin
                n_fail++; $display("FAIL rstmid_no_accept cycle %0d got %b exp 0000", c, {cfg_in_ready, weightValid, biasValid, busy}); end
        end
        cfg_in_valid = 1'b0;
    endtask

`ifdef NN_CFG_CHECKSUM_EN
    task automatic test_checksum_mismatch();
        exp_checksum = 32'd67;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int w = 1; w <= 11; w++) begin
            cfg_in_valid = 1'b1; cfg_in_data = 32'(w);
            @(posedge clk); #1;
        end
        cfg_in_valid = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (done !== 1'b1 || cfg_checksum !== 32'd66) begin
            n_fail++; $display("FAIL cksum_bad_done got done=%0b sum=%0d exp 1 66", done, cfg_checksum); end
        n_tests++; if (loaded !== 1'b0 || cksum_err !== 1'b1) begin
            n_fail++; $display("FAIL cksum_bad_flags got loaded=%0b err=%0b exp 0 1", loaded, cksum_err); end
        exp_checksum = 32'd66;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        rst_n = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_in_valid = 1'b0; cfg_in_data = '0;
`ifdef NN_CFG_CHECKSUM_EN
        exp_checksum = 32'd66;
`endif
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_load(1'b0, 0, "continuous");
        test_load(1'b1, 0, "gaps");
        test_abort();
        test_load(1'b0, 0, "after_abort");
        test_load(1'b0, 3, "start_mid");
        test_reset_mid();
        test_load(1'b0, 0, "after_reset");
`ifdef NN_CFG_CHECKSUM_EN
        test_checksum_mismatch();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
